// File: rtl/cp0_ctrl_pkg.sv
// cp0_ctrl_pkg: shared definitions for the exception/interrupt/ERET commit path.
//   - seq_state_t  : commit sequencer FSM states
//   - EXC_*        : MIPS ExcCode values driven to CP0 Cause
//   - EB_*         : bit positions inside the MEM-stage mem_exc vector
//   - *_DEF        : default exception vector bases and general offset
//   - prio_t       : priority-encoder result record
package cp0_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_REDIRECT = 2'd3
    } seq_state_t;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // mem_exc bit positions; bit 0 is the highest priority
    localparam int EB_ADEL_I = 0;
    localparam int EB_TLBL_I = 1;
    localparam int EB_RI     = 2;
    localparam int EB_OV     = 3;
    localparam int EB_SYS    = 4;
    localparam int EB_BRK    = 5;
    localparam int EB_ADEL_D = 6;
    localparam int EB_ADES   = 7;
    localparam int EB_TLBL_D = 8;
    localparam int EB_TLBS   = 9;
    localparam int EB_MOD    = 10;
    localparam int EXC_BITS  = 11;

    localparam logic [31:0] VEC_BEV_DEF  = 32'hBFC0_0200;
    localparam logic [31:0] VEC_NORM_DEF = 32'h8000_0000;
    localparam logic [31:0] GEN_OFS_DEF  = 32'h0000_0180;

    typedef struct packed {
        logic       hit;
        logic       is_eret;
        logic [4:0] code;
        logic       is_refill;  // winner is a TLB-class fault (may use the refill vector)
    } prio_t;

    function automatic logic [4:0] exc_code_of(input int idx);
        logic [4:0] c;
        case (idx)
            EB_ADEL_I, EB_ADEL_D: c = EXC_ADEL;
            EB_TLBL_I, EB_TLBL_D: c = EXC_TLBL;
            EB_RI:                c = EXC_RI;
            EB_OV:                c = EXC_OV;
            EB_SYS:               c = EXC_SYS;
            EB_BRK:               c = EXC_BP;
            EB_ADES:              c = EXC_ADES;
            EB_TLBS:              c = EXC_TLBS;
            EB_MOD:               c = EXC_MOD;
            default:              c = EXC_INT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: combinational priority encoder for the commit sequencer.
//   int_pending : enabled-and-pending interrupt (highest priority)
//   mem_exc     : MEM-stage exception flags, bit 0 highest
//   mem_eret    : MEM instruction is ERET (lowest priority)
//   res         : {hit, is_eret, code, is_refill} of the winning source
module exc_prio_enc
    import cp0_ctrl_pkg::*;
(
    input  logic                int_pending,
    input  logic [EXC_BITS-1:0] mem_exc,
    input  logic                mem_eret,
    output prio_t               res
);

    always_comb begin
        res = '0;
        if (int_pending) begin
            res.hit  = 1'b1;
            res.code = EXC_INT;
        end else if (|mem_exc) begin
            res.hit = 1'b1;
            // Walk from lowest to highest priority so the last match wins.
            for (int i = EXC_BITS - 1; i >= 0; i--) begin
                if (mem_exc[i]) begin
                    res.code      = exc_code_of(i);
                    res.is_refill = (i == EB_TLBL_I) || (i == EB_TLBL_D) || (i == EB_TLBS);
                end
            end
        end else if (mem_eret) begin
            res.hit     = 1'b1;
            res.is_eret = 1'b1;
        end
    end

endmodule

// File: rtl/exc_commit_sequencer.sv
// exc_commit_sequencer: arbitrates MEM-stage exceptions, interrupts and ERET,
// emits one commit pulse to CP0, holds flush over a drain window and then
// hands a redirect PC to fetch.
//   clk, resetn               : clock, synchronous active-low reset
//   mem_valid/pc/exc/eret     : MEM-stage instruction and its fault flags
//   mem_tlb_refill            : TLB fault is a miss rather than an invalid entry
//   int_pending               : CP0 interrupt request
//   sr_exl, sr_bev, cp0_epc   : CP0 state used to pick the redirect target
//   redirect_ready            : fetch accepts the redirect
//   exc_commit/exc_code       : exception commit pulse and its ExcCode
//   eret_commit               : ERET commit pulse
//   flush                     : kill IF..MEM, block writeback
//   redirect_valid/pc         : new fetch address handshake
//   busy                      : sequencer is not idle
module exc_commit_sequencer
    import cp0_ctrl_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] VEC_BEV      = VEC_BEV_DEF,
    parameter logic [31:0] VEC_NORM     = VEC_NORM_DEF,
    parameter logic [31:0] GEN_OFS      = GEN_OFS_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_valid,
    input  logic [31:0]         mem_pc,
    input  logic [EXC_BITS-1:0] mem_exc,
    input  logic                mem_tlb_refill,
    input  logic                mem_eret,
    input  logic                int_pending,
    input  logic                sr_exl,
    input  logic                sr_bev,
    input  logic [31:0]         cp0_epc,
    input  logic                redirect_ready,
    output logic                exc_commit,
    output logic [4:0]          exc_code,
    output logic                eret_commit,
    output logic                flush,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    output logic                busy
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    seq_state_t        state;
    logic [CNT_W-1:0]  drain_cnt;
    logic              eret_q;
    logic [31:0]       target;
    prio_t             win;
    logic              trigger;
    logic [31:0]       vec_target;

    // CP0 captures EPC from the MEM stage itself; the PC is carried here only
    // to keep the MEM interface uniform.
    logic unused_pc;
    assign unused_pc = ^mem_pc;

    exc_prio_enc u_prio (
        .int_pending (int_pending),
        .mem_exc     (mem_exc),
        .mem_eret    (mem_eret),
        .res         (win)
    );

    assign trigger = mem_valid & win.hit;

    // Refill vector (offset 0) only for a true TLB miss taken outside EXL.
    assign vec_target = (sr_bev ? VEC_BEV : VEC_NORM)
                      + ((win.is_refill & mem_tlb_refill & ~sr_exl) ? 32'h0 : GEN_OFS);

    assign redirect_pc = target;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            drain_cnt      <= '0;
            eret_q         <= 1'b0;
            target         <= '0;
            exc_commit     <= 1'b0;
            exc_code       <= '0;
            eret_commit    <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
        end else begin
            exc_commit  <= 1'b0;
            eret_commit <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state       <= ST_COMMIT;
                        eret_q      <= win.is_eret;
                        exc_commit  <= ~win.is_eret;
                        eret_commit <= win.is_eret;
                        exc_code    <= win.is_eret ? 5'd0 : win.code;
                        flush       <= 1'b1;
                        busy        <= 1'b1;
                        if (!win.is_eret)
                            target <= vec_target;
                    end
                end
                ST_COMMIT: begin
                    state     <= ST_DRAIN;
                    drain_cnt <= CNT_W'(FLUSH_CYCLES - 1);
                    // EPC is taken here so a same-cycle mtc0 to EPC is honoured.
                    if (eret_q)
                        target <= cp0_epc;
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state          <= ST_REDIRECT;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= ST_IDLE;
                        redirect_valid <= 1'b0;
                        busy           <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_commit_sequencer.sv
// Directed bench with a commit scoreboard: each trigger pushes its expected
// {code, kind, target}; the monitor pops on every commit pulse and checks the
// redirect PC at the fetch handshake. A second instance built with
// FLUSH_CYCLES=1 covers the minimum-latency case.
module tb_exc_commit_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, mem_valid1;
    logic [31:0] mem_pc;
    logic [10:0] mem_exc;
    logic        mem_tlb_refill, mem_eret, int_pending, sr_exl, sr_bev;
    logic [31:0] cp0_epc;
    logic        redirect_ready;

    logic        exc_commit, eret_commit, flush, redirect_valid, busy;
    logic [4:0]  exc_code;
    logic [31:0] redirect_pc;
    logic        exc_commit1, eret_commit1, flush1, redirect_valid1, busy1;
    logic [4:0]  exc_code1;
    logic [31:0] redirect_pc1;

    always #5 clk = ~clk;

    exc_commit_sequencer u_dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_exc(mem_exc), .mem_tlb_refill(mem_tlb_refill), .mem_eret(mem_eret),
        .int_pending(int_pending), .sr_exl(sr_exl), .sr_bev(sr_bev),
        .cp0_epc(cp0_epc), .redirect_ready(redirect_ready),
        .exc_commit(exc_commit), .exc_code(exc_code), .eret_commit(eret_commit),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy)
    );

    exc_commit_sequencer #(.FLUSH_CYCLES(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid1), .mem_pc(mem_pc),
        .mem_exc(mem_exc), .mem_tlb_refill(mem_tlb_refill), .mem_eret(mem_eret),
        .int_pending(int_pending), .sr_exl(sr_exl), .sr_bev(sr_bev),
        .cp0_epc(cp0_epc), .redirect_ready(redirect_ready),
        .exc_commit(exc_commit1), .exc_code(exc_code1), .eret_commit(eret_commit1),
        .flush(flush1), .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
        .busy(busy1)
    );

    typedef struct {
        logic [4:0]  code;
        logic        eret;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic cur_vld = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        mem_valid      = 1'b0;
        mem_valid1     = 1'b0;
        mem_exc        = '0;
        mem_eret       = 1'b0;
        int_pending    = 1'b0;
        mem_tlb_refill = 1'b0;
    endtask

    task automatic fire(input logic [10:0] exc, input logic refill, input logic eret,
                        input logic intp, input logic exl, input logic bev,
                        input logic [31:0] pc, input logic [4:0] code,
                        input logic is_eret, input logic [31:0] tgt);
        exp_t e;
        e.code = code; e.eret = is_eret; e.tgt = tgt;
        sb.push_back(e);
        mem_valid = 1'b1; mem_pc = pc; mem_exc = exc; mem_tlb_refill = refill;
        mem_eret = eret; int_pending = intp; sr_exl = exl; sr_bev = bev;
    endtask

    // Fire, then run with redirect_ready=1 until the sequence returns idle.
    task automatic run(input logic [10:0] exc, input logic refill, input logic exl,
                       input logic bev, input logic [4:0] code, input logic [31:0] tgt,
                       output int lat);
        fire(exc, refill, 1'b0, 1'b0, exl, bev, 32'h8000_0100, code, 1'b0, tgt);
        tick();
        clr();
        lat = 1;
        while (!redirect_valid && lat < 20) begin
            tick();
            lat++;
        end
        tick();
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (!resetn) begin
            cur_vld = 1'b0;
        end else begin
            if (exc_commit || eret_commit) begin
                chk("sb_nonempty_at_commit", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    cur_vld = 1'b1;
                    chk("commit_eret", eret_commit, cur.eret);
                    chk("commit_exc", exc_commit, !cur.eret);
                    if (!cur.eret) chk("exc_code", exc_code, cur.code);
                end
            end
            if (redirect_valid && redirect_ready) begin
                chk("redirect_expected", cur_vld, 1);
                if (cur_vld) chk("redirect_pc", redirect_pc, cur.tgt);
                cur_vld = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, fcnt, pulses;
        resetn = 1'b0; clr(); mem_pc = '0; sr_exl = 1'b0; sr_bev = 1'b0;
        cp0_epc = '0; redirect_ready = 1'b0;
        tick(); tick();
        chk("rst_exc_commit", exc_commit, 0);
        chk("rst_eret_commit", eret_commit, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_busy1", busy1, 0);
        resetn = 1'b1;
        tick();

        // RI, BEV=1: general offset off the boot vector, 3 flush cycles
        redirect_ready = 1'b1;
        fire(11'h004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0010, 5'hA, 1'b0, 32'hBFC0_0380);
        tick();
        clr();
        chk("ri_exc_commit", exc_commit, 1);
        chk("ri_eret_commit", eret_commit, 0);
        chk("ri_code", exc_code, 5'hA);
        chk("ri_busy", busy, 1);
        fcnt = flush ? 1 : 0;
        lat = 1;
        while (!redirect_valid && lat < 20) begin
            tick();
            lat++;
            if (flush) fcnt++;
        end
        chk("ri_flush_cycles", fcnt, 3);
        chk("ri_latency", lat, 4);
        chk("ri_flush_at_redirect", flush, 0);
        chk("ri_redirect_pc", redirect_pc, 32'hBFC0_0380);
        tick();
        chk("ri_idle_busy", busy, 0);
        chk("ri_idle_rv", redirect_valid, 0);

        // TLB load miss on data, EXL=0 -> refill vector; EXL=1 -> general
        run(11'h100, 1'b1, 1'b0, 1'b0, 5'd2, 32'h8000_0000, lat);
        chk("tlbl_refill_latency", lat, 4);
        run(11'h100, 1'b1, 1'b1, 1'b0, 5'd2, 32'h8000_0180, lat);
        chk("tlbl_exl_busy", busy, 0);
        // TLB invalid (not a miss) also uses the general vector
        run(11'h200, 1'b0, 1'b0, 1'b0, 5'd3, 32'h8000_0180, lat);
        // adel_i beats ov
        run(11'h009, 1'b0, 1'b0, 1'b0, 5'd4, 32'h8000_0180, lat);

        // Interrupt with ov+sys held high while busy: exactly one commit
        redirect_ready = 1'b0;
        fire(11'h018, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0200, 5'd0, 1'b0, 32'h8000_0180);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (exc_commit || eret_commit) pulses++;
        end
        chk("int_single_commit", pulses, 1);
        chk("int_busy", busy, 1);
        chk("int_redirect_valid", redirect_valid, 1);
        clr();
        redirect_ready = 1'b1;
        tick();
        chk("int_idle", busy, 0);
        tick();
        chk("int_no_retrigger", busy, 0);

        // ERET: EPC sampled in the commit cycle, redirect held back
        redirect_ready = 1'b0;
        cp0_epc = 32'h0BAD_0000;
        fire(11'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0300, 5'd0, 1'b1, 32'h8000_1234);
        tick();
        clr();
        cp0_epc = 32'h8000_1234;
        chk("eret_commit", eret_commit, 1);
        chk("eret_no_exc_commit", exc_commit, 0);
        tick();
        cp0_epc = 32'hDEAD_0000;
        lat = 2;
        while (!redirect_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("eret_latency", lat, 4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("eret_pc_stable", redirect_pc, 32'h8000_1234);
            chk("eret_busy_hold", busy, 1);
            chk("eret_rv_hold", redirect_valid, 1);
        end
        redirect_ready = 1'b1;
        tick();
        chk("eret_idle", busy, 0);

        // Reset during DRAIN
        fire(11'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0400, 5'd8, 1'b0, 32'h8000_0180);
        tick();
        clr();
        tick();
        chk("drain_flush", flush, 1);
        chk("drain_no_pulse", exc_commit, 0);
        resetn = 1'b0;
        tick();
        chk("mid_rst_exc_commit", exc_commit, 0);
        chk("mid_rst_eret_commit", eret_commit, 0);
        chk("mid_rst_flush", flush, 0);
        chk("mid_rst_rv", redirect_valid, 0);
        chk("mid_rst_pc", redirect_pc, 0);
        chk("mid_rst_code", exc_code, 0);
        chk("mid_rst_busy", busy, 0);
        resetn = 1'b1;
        tick();
        run(11'h020, 1'b0, 1'b0, 1'b1, 5'd9, 32'hBFC0_0380, lat);
        chk("post_rst_latency", lat, 4);

        // FLUSH_CYCLES=1 instance: trigger-to-redirect is 3 cycles
        mem_valid1 = 1'b1; mem_exc = 11'h004; sr_bev = 1'b0; sr_exl = 1'b0;
        tick();
        clr();
        chk("f1_exc_commit", exc_commit1, 1);
        chk("f1_code", exc_code1, 5'hA);
        lat = 1;
        while (!redirect_valid1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("f1_latency", lat, 3);
        chk("f1_redirect_pc", redirect_pc1, 32'h8000_0180);
        chk("f1_flush_off", flush1, 0);
        chk("f1_other_idle", busy, 0);
        tick();
        chk("f1_idle", busy1, 0);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
